// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, counter width and arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam int DATA_LENGTH = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2
  } arb_state_t;

  // Saturating decrement used by the inter-frame gap counter.
  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the SPI TX arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold REQ/DATA_IN until ACK; the engine reports progress through SS_N.
interface spi_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DL    = spi_pkg::DATA_LENGTH
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    REQ;
  logic [N_REQ*DL-1:0] DATA_IN;
  logic [N_REQ-1:0]    ACK;
  logic                ERR;
  logic                BUSY;
  logic [IW-1:0]       GRANT_ID;
  logic                GO;
  logic [DL-1:0]       TX_DATA;
  logic                SS_N;

  // Arbiter side.
  modport master (
    input  REQ, DATA_IN, SS_N,
    output ACK, ERR, BUSY, GRANT_ID, GO, TX_DATA
  );

  // Requester / engine side.
  modport slave (
    output REQ, DATA_IN, SS_N,
    input  ACK, ERR, BUSY, GRANT_ID, GO, TX_DATA
  );
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set REQ bit at or after PTR, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; VALID is simply |REQ.
module spi_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] REQ,
  input  logic [IW-1:0]    PTR,
  output logic             VALID,
  output logic [IW-1:0]    WINNER
);

  logic [IW-1:0] sel;

  // Scan from the pointer outward; the first hit is kept.
  always_comb begin
    VALID  = 1'b0;
    WINNER = '0;
    sel    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel = IW'((int'(PTR) + i) % N_REQ);
      if (!VALID && REQ[sel]) begin
        VALID  = 1'b1;
        WINNER = sel;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin sharing of one SPI TX engine: grant, one-cycle GO, track SS_N, ACK, enforce gap.
// Latency: GO one cycle after grant decision; ACK the cycle after SS_N is seen high again.
// Backpressure: no grant while gap counter runs or SS_N is low; requesters hold REQ until ACK.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 4
) (
  input logic               CLK,
  input logic               RST,
  spi_tx_arbiter_if.master  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(START_TIMEOUT);
  localparam logic [IW-1:0]    LAST_ID  = IW'(N_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   go_q, go_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [IW-1:0]          gid_q, gid_d;
  logic [DATA_LENGTH-1:0] tx_q, tx_d;

  logic                   pick_vld;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          ptr_after;

  spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .REQ    (bus.REQ),
    .PTR    (ptr_q),
    .VALID  (pick_vld),
    .WINNER (pick_idx)
  );

  // Pointer moves just past the requester that was served so others go first.
  assign ptr_after = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    go_d    = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    gid_d   = gid_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (gap_q != '0) begin
          gap_d = cnt_dec(gap_q);
        end else if (pick_vld && bus.SS_N) begin
          tx_d    = bus.DATA_IN[int'(pick_idx)*DATA_LENGTH +: DATA_LENGTH];
          gid_d   = pick_idx;
          go_d    = 1'b1;
          tmo_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (!bus.SS_N) begin
          state_d = ACTIVE;
        end else if (tmo_q == TMO_MAX) begin
          err_d        = 1'b1;
          ack_d[gid_q] = 1'b1;
          ptr_d        = ptr_after;
          gap_d        = GAP_INIT;
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.SS_N) begin
          ack_d[gid_q] = 1'b1;
          ptr_d        = ptr_after;
          gap_d        = GAP_INIT;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops everything back to IDLE at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      go_q    <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      go_q    <= go_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.GO       = go_q;
  assign bus.ACK      = ack_q;
  assign bus.ERR      = err_q;
  assign bus.BUSY     = busy_q;
  assign bus.GRANT_ID = gid_q;
  assign bus.TX_DATA  = tx_q;

endmodule
